// File: rtl/spi_master_burst.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_burst
// Description : Mode-0, MSB-first SPI master that frames multi-byte bursts
//               under a single chip-select assertion.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_burst #(
    parameter int CLK_DIV  = 2,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    input  logic       tx_last_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       busy_o,
    output logic       cs_n_o,
    output logic       sclk_o,
    output logic       mosi_o,
    input  logic       miso_i
);

    localparam int c_MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int c_MAX   = (c_MAX_A > CS_HOLD) ? c_MAX_A : CS_HOLD;
    localparam int c_CNT_W = (c_MAX > 1) ? $clog2(c_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_DIV_LAST   = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(CS_SETUP - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(CS_HOLD - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SETUP = 3'd1;
    localparam logic [2:0] c_XFER  = 3'd2;
    localparam logic [2:0] c_NEXT  = 3'd3;
    localparam logic [2:0] c_HOLD  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [6:0]         txsh_q, txsh_d;   // bit 7 goes straight to mosi on accept
    logic [7:0]         rxsh_q, rxsh_d;
    logic               last_q, last_d;
    logic               cs_n_q, cs_n_d;
    logic               sclk_q, sclk_d;
    logic               mosi_q, mosi_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= c_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            txsh_q     <= '0;
            rxsh_q     <= '0;
            last_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            txsh_q     <= txsh_d;
            rxsh_q     <= rxsh_d;
            last_q     <= last_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        txsh_d     = txsh_q;
        rxsh_d     = rxsh_q;
        last_d     = last_q;
        cs_n_d     = cs_n_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        w_accept   = tx_valid_i & tx_ready_o;
        case (state_q)
            c_IDLE: begin
                if (w_accept) begin
                    txsh_d  = tx_data_i[6:0];
                    last_d  = tx_last_i;
                    mosi_d  = tx_data_i[7];
                    cs_n_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = c_SETUP;
                end
            end
            c_SETUP: begin
                if (cnt_q == c_SETUP_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = c_XFER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            c_XFER: begin
                if (cnt_q != c_DIV_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rxsh_d = {rxsh_q[6:0], miso_i};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q != 3'd7) begin
                            bit_d  = bit_q + 3'd1;
                            mosi_d = txsh_q[6];
                            txsh_d = {txsh_q[5:0], 1'b0};
                        end else begin
                            rx_data_d  = rxsh_q;
                            rx_valid_d = 1'b1;
                            state_d    = last_q ? c_HOLD : c_NEXT;
                        end
                    end
                end
            end
            c_NEXT: begin
                if (w_accept) begin
                    txsh_d  = tx_data_i[6:0];
                    last_d  = tx_last_i;
                    mosi_d  = tx_data_i[7];
                    bit_d   = '0;
                    cnt_d   = '0;
                    state_d = c_XFER;
                end
            end
            c_HOLD: begin
                if (cnt_q == c_HOLD_LAST) begin
                    cs_n_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = c_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        tx_ready_o = (state_q == c_IDLE) || (state_q == c_NEXT);
        busy_o     = (state_q != c_IDLE);
    end

    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign cs_n_o     = cs_n_q;
    assign sclk_o     = sclk_q;
    assign mosi_o     = mosi_q;

endmodule
`default_nettype wire
